// File: rtl/cpu_pkg.sv
// Shared RV32 pipeline types: load funct3 encodings, opcodes, mul/div entry.
package cpu_pkg;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_OPIMM  = 7'b0010011,
        OP_OP     = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111
    } opcode_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } md_entry_t;

    function automatic logic [31:0] load_format(
        input logic [2:0]  f3,
        input logic [1:0]  lo,
        input logic [31:0] rdata
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            F3_LB:   r = {{24{b[7]}}, b};
            F3_LH:   r = {{16{h[15]}}, h};
            F3_LBU:  r = {24'd0, b};
            F3_LHU:  r = {16'd0, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_md_fifo.sv
// Circular buffer of late mul/div results with per-entry valid,
// squash-by-rd and a pending-destination mask.
module wb_md_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  logic [4:0]  push_rd_i,
    input  logic [31:0] push_data_i,
    input  logic        pop_i,
    input  logic        squash_i,
    input  logic [4:0]  squash_rd_i,
    output logic        head_valid_o,
    output logic [4:0]  head_rd_o,
    output logic [31:0] head_data_o,
    output logic        empty_o,
    output logic        ready_o,
    output logic [31:0] pend_mask_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    md_entry_t        mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ready_q;

    always_comb begin
        vld_d = vld_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (squash_i && mem_q[i].rd == squash_rd_i) begin
                vld_d[i] = 1'b0;
            end
        end
        if (pop_i) begin
            vld_d[rd_q] = 1'b0;
        end
        if (push_i) begin
            vld_d[wr_q] = 1'b1;
        end
    end

    assign cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            ready_q <= (cnt_d < CW'(DEPTH));
            if (push_i) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop_i) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    // Payload needs no reset: only entries with vld_q set are ever observed.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= '{rd: push_rd_i, data: push_data_i};
        end
    end

    always_comb begin
        pend_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) begin
                pend_mask_o[mem_q[i].rd] = 1'b1;
            end
        end
    end

    assign head_valid_o = vld_q[rd_q];
    assign head_rd_o    = mem_q[rd_q].rd;
    assign head_data_o  = mem_q[rd_q].data;
    assign empty_o      = (cnt_q == '0);
    assign ready_o      = ready_q;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: formats MEM results and merges buffered mul/div results.
// WB_MD_PORT_EN enables the mul/div port, buffer, pend_mask and stall logic.
module wb_stage
    import cpu_pkg::*;
#(
    parameter int MD_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic        mem_reg_write,
    input  logic        mem_memtoreg,
    input  logic        mem_link,
    input  logic [4:0]  mem_rd,
    input  logic [2:0]  mem_funct3,
    input  logic [1:0]  mem_addr_lo,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] mem_pc_plus4,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_result,
    output logic        reg_write,
    output logic [4:0]  rd_wb,
    output logic [31:0] wd,
    output logic [31:0] pend_mask,
    output logic        wb_stall
);

    logic        pipe_wr;
    logic [31:0] pipe_wd;
    logic        md_pop;
    logic        md_wr;
    logic [4:0]  md_head_rd;
    logic [31:0] md_head_data;
    logic        rw_d, rw_q;
    logic [4:0]  rd_d, rd_q;
    logic [31:0] wd_d, wd_q;

    assign pipe_wr = mem_valid && mem_reg_write;

    always_comb begin
        if (mem_link) begin
            pipe_wd = mem_pc_plus4;
        end else if (mem_memtoreg) begin
            pipe_wd = load_format(mem_funct3, mem_addr_lo, mem_rdata);
        end else begin
            pipe_wd = mem_alu_result;
        end
    end

    // x0 targets still consume the slot but never raise reg_write.
    always_comb begin
        rw_d = 1'b0;
        rd_d = '0;
        wd_d = '0;
        if (pipe_wr) begin
            if (mem_rd != 5'd0) begin
                rw_d = 1'b1;
                rd_d = mem_rd;
                wd_d = pipe_wd;
            end
        end else if (md_pop && md_wr) begin
            rw_d = 1'b1;
            rd_d = md_head_rd;
            wd_d = md_head_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q <= 1'b0;
            rd_q <= '0;
            wd_q <= '0;
        end else begin
            rw_q <= rw_d;
            rd_q <= rd_d;
            wd_q <= wd_d;
        end
    end

    assign reg_write = rw_q;
    assign rd_wb     = rd_q;
    assign wd        = wd_q;

`ifdef WB_MD_PORT_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic          md_push;
    logic          fifo_empty;
    logic          head_valid;
    logic          lose;
    logic [SW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;

    assign md_push = md_valid && md_ready;
    assign md_pop  = !fifo_empty && !pipe_wr;
    assign md_wr   = head_valid && (md_head_rd != 5'd0);
    assign lose    = !fifo_empty && pipe_wr;

    wb_md_fifo #(
        .DEPTH (MD_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (md_push),
        .push_rd_i    (md_rd),
        .push_data_i  (md_result),
        .pop_i        (md_pop),
        .squash_i     (pipe_wr && (mem_rd != 5'd0)),
        .squash_rd_i  (mem_rd),
        .head_valid_o (head_valid),
        .head_rd_o    (md_head_rd),
        .head_data_o  (md_head_data),
        .empty_o      (fifo_empty),
        .ready_o      (md_ready),
        .pend_mask_o  (pend_mask)
    );

    // The counter clears on the stall so the bubble is a single cycle.
    always_comb begin
        starve_d = '0;
        stall_d  = 1'b0;
        if (lose) begin
            if (starve_q == SW'(STARVE_MAX - 1)) begin
                stall_d = 1'b1;
            end else begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign wb_stall = stall_q;
`else
    logic unused_md;
    assign unused_md = ^{md_valid, md_rd, md_result,
                         1'(MD_DEPTH), 1'(STARVE_MAX)};

    assign md_pop       = 1'b0;
    assign md_wr        = 1'b0;
    assign md_head_rd   = '0;
    assign md_head_data = '0;
    assign md_ready     = 1'b0;
    assign pend_mask    = '0;
    assign wb_stall     = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with a queue-based reference model.
// Covers both the RV32I build and the WB_MD_PORT_EN build.
module tb_wb_stage;

    localparam int MD_DEPTH   = 2;
    localparam int STARVE_MAX = 4;
`ifdef WB_MD_PORT_EN
    localparam logic MD_ON = 1'b1;
`else
    localparam logic MD_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        mem_valid, mem_reg_write, mem_memtoreg, mem_link;
    logic [4:0]  mem_rd;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_alu_result, mem_rdata, mem_pc_plus4;
    logic        md_valid, md_ready;
    logic [4:0]  md_rd;
    logic [31:0] md_result;
    logic        reg_write;
    logic [4:0]  rd_wb;
    logic [31:0] wd;
    logic [31:0] pend_mask;
    logic        wb_stall;

    int errors = 0;
    int checks = 0;

    wb_stage #(
        .MD_DEPTH   (MD_DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_valid      (mem_valid),
        .mem_reg_write  (mem_reg_write),
        .mem_memtoreg   (mem_memtoreg),
        .mem_link       (mem_link),
        .mem_rd         (mem_rd),
        .mem_funct3     (mem_funct3),
        .mem_addr_lo    (mem_addr_lo),
        .mem_alu_result (mem_alu_result),
        .mem_rdata      (mem_rdata),
        .mem_pc_plus4   (mem_pc_plus4),
        .md_valid       (md_valid),
        .md_ready       (md_ready),
        .md_rd          (md_rd),
        .md_result      (md_result),
        .reg_write      (reg_write),
        .rd_wb          (rd_wb),
        .wd             (wd),
        .pend_mask      (pend_mask),
        .wb_stall       (wb_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Reference model: expected outputs for the cycle after each edge.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
        bit          live;
    } ent_t;

    ent_t        q[$];
    logic        e_rw  = 1'b0;
    logic [4:0]  e_rd  = '0;
    logic [31:0] e_wd  = '0;
    logic        e_st  = 1'b0;
    logic        e_rdy = 1'b0;
    logic [31:0] e_pm  = '0;
    int          lost  = 0;

    function automatic logic [31:0] pipe_val();
        logic [31:0] b, h;
        if (mem_link) return mem_pc_plus4;
        if (!mem_memtoreg) return mem_alu_result;
        b = (mem_rdata >> (8 * mem_addr_lo)) & 32'hFF;
        h = (mem_rdata >> (mem_addr_lo[1] ? 16 : 0)) & 32'hFFFF;
        case (mem_funct3)
            3'b000:  return (b >= 32'h80) ? b - 32'h100 : b;
            3'b001:  return (h >= 32'h8000) ? h - 32'h10000 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return mem_rdata;
        endcase
    endfunction

    task automatic model_step();
        logic pipe;
`ifdef WB_MD_PORT_EN
        bit   have, acc;
        ent_t e;
`endif
        if (!rst_n) begin
            q.delete();
            e_rw = 0; e_rd = 0; e_wd = 0;
            e_st = 0; e_rdy = 0; e_pm = 0; lost = 0;
            return;
        end
        pipe = mem_valid && mem_reg_write;
        e_rw = 0; e_rd = 0; e_wd = 0;
`ifdef WB_MD_PORT_EN
        have = q.size() > 0;
        acc  = md_valid && e_rdy;
`endif
        if (pipe) begin
            if (mem_rd != 0) begin
                e_rw = 1; e_rd = mem_rd; e_wd = pipe_val();
`ifdef WB_MD_PORT_EN
                foreach (q[i]) if (q[i].rd == mem_rd) q[i].live = 0;
`endif
            end
        end
`ifdef WB_MD_PORT_EN
        else if (have) begin
            e = q.pop_front();
            if (e.live && e.rd != 0) begin
                e_rw = 1; e_rd = e.rd; e_wd = e.d;
            end
        end
        e_st = 0;
        if (have && pipe) begin
            lost++;
            if (lost == STARVE_MAX) begin
                e_st = 1;
                lost = 0;
            end
        end else begin
            lost = 0;
        end
        if (acc) q.push_back('{md_rd, md_result, 1'b1});
        e_rdy = q.size() < MD_DEPTH;
        e_pm  = 0;
        foreach (q[i]) if (q[i].live) e_pm[q[i].rd] = 1'b1;
`endif
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("cmp_reg_write", {31'd0, reg_write}, {31'd0, e_rw});
        chk("cmp_rd_wb", {27'd0, rd_wb}, {27'd0, e_rd});
        chk("cmp_wd", wd, e_wd);
        chk("cmp_pend_mask", pend_mask, e_pm);
        chk("cmp_wb_stall", {31'd0, wb_stall}, {31'd0, e_st});
        chk("cmp_md_ready", {31'd0, md_ready}, {31'd0, e_rdy});
    end

    task automatic pipe(input logic v, input logic rw, input logic m2r,
                        input logic lnk, input logic [4:0] rd,
                        input logic [2:0] f3, input logic [1:0] lo,
                        input logic [31:0] alu, input logic [31:0] rdat,
                        input logic [31:0] pc4);
        mem_valid      = v;
        mem_reg_write  = rw;
        mem_memtoreg   = m2r;
        mem_link       = lnk;
        mem_rd         = rd;
        mem_funct3     = f3;
        mem_addr_lo    = lo;
        mem_alu_result = alu;
        mem_rdata      = rdat;
        mem_pc_plus4   = pc4;
        @(posedge clk);
        #1;
    endtask

    task automatic alu_wr(input logic [4:0] rd, input logic [31:0] v);
        pipe(1, 1, 0, 0, rd, 3'd0, 2'd0, v, 32'd0, 32'd0);
    endtask

    task automatic load(input logic [4:0] rd, input logic [2:0] f3,
                        input logic [1:0] lo, input logic [31:0] rdat);
        pipe(1, 1, 1, 0, rd, f3, lo, 32'hBAD0BAD0, rdat, 32'h0);
    endtask

    task automatic idle();
        pipe(0, 0, 0, 0, 5'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic chk_wr(input string nm, input logic [4:0] rd,
                          input logic [31:0] v);
        chk({nm, "_rw"}, {31'd0, reg_write}, 32'd1);
        chk({nm, "_rd"}, {27'd0, rd_wb}, {27'd0, rd});
        chk({nm, "_wd"}, wd, v);
    endtask

    initial begin
        rst_n = 1'b0;
        md_valid = 0; md_rd = 0; md_result = 0;
        mem_valid = 0; mem_reg_write = 0; mem_memtoreg = 0;
        mem_link = 0; mem_rd = 0; mem_funct3 = 0; mem_addr_lo = 0;
        mem_alu_result = 0; mem_rdata = 0; mem_pc_plus4 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rw", {31'd0, reg_write}, 32'd0);
        chk("rst_wd", wd, 32'd0);
        chk("rst_rdy", {31'd0, md_ready}, 32'd0);
        chk("rst_pm", pend_mask, 32'd0);
        rst_n = 1'b1;
        idle();
        chk("rdy_rel", {31'd0, md_ready}, {31'd0, MD_ON});

        alu_wr(5'd3, 32'h1234);
        chk_wr("alu", 5'd3, 32'h1234);
        load(5'd4, 3'b000, 2'd2, 32'h00800000);
        chk_wr("lb", 5'd4, 32'hFFFFFF80);
        load(5'd4, 3'b100, 2'd2, 32'h00800000);
        chk_wr("lbu", 5'd4, 32'h00000080);
        load(5'd6, 3'b001, 2'd2, 32'h80000000);
        chk_wr("lh", 5'd6, 32'hFFFF8000);
        load(5'd6, 3'b101, 2'd2, 32'h80000000);
        chk_wr("lhu", 5'd6, 32'h00008000);
        load(5'd8, 3'b010, 2'd0, 32'hDEADBEEF);
        chk_wr("lw", 5'd8, 32'hDEADBEEF);
        load(5'd8, 3'b011, 2'd3, 32'h12345678);
        chk_wr("f3_011", 5'd8, 32'h12345678);
        load(5'd9, 3'b000, 2'd1, 32'h00007F00);
        chk_wr("lb_pos", 5'd9, 32'h0000007F);
        load(5'd9, 3'b001, 2'd0, 32'h00008001);
        chk_wr("lh_lo", 5'd9, 32'hFFFF8001);
        pipe(1, 1, 1, 1, 5'd1, 3'd0, 2'd0, 32'h5, 32'h7, 32'h100);
        chk_wr("link", 5'd1, 32'h100);
        alu_wr(5'd0, 32'hFFFF);
        chk("x0_rw", {31'd0, reg_write}, 32'd0);
        pipe(1, 0, 0, 0, 5'd2, 3'd0, 2'd0, 32'h77, 32'd0, 32'd0);
        chk("norw", {31'd0, reg_write}, 32'd0);
        pipe(0, 1, 0, 0, 5'd2, 3'd0, 2'd0, 32'h77, 32'd0, 32'd0);
        chk("novalid", {31'd0, reg_write}, 32'd0);

`ifdef WB_MD_PORT_EN
        md_valid = 1; md_rd = 5'd5; md_result = 32'hC0FFEE;
        alu_wr(5'd1, 32'h11);
        md_valid = 0;
        chk("pend5", pend_mask, 32'h20);
        for (int i = 2; i <= 4; i++) alu_wr(5'(i), 32'(i));
        chk("no_stall_yet", {31'd0, wb_stall}, 32'd0);
        alu_wr(5'd1, 32'h22);
        chk("stall", {31'd0, wb_stall}, 32'd1);
        idle();
        chk_wr("md_bubble", 5'd5, 32'hC0FFEE);
        chk("pend5_clr", pend_mask, 32'd0);
        chk("stall_1cyc", {31'd0, wb_stall}, 32'd0);

        md_valid = 1; md_rd = 5'd7; md_result = 32'hAAAA;
        alu_wr(5'd1, 32'h33);
        md_valid = 0;
        chk("pend7", pend_mask, 32'h80);
        alu_wr(5'd7, 32'h5555);
        chk_wr("waw", 5'd7, 32'h5555);
        chk("waw_pm", pend_mask, 32'd0);
        idle();
        chk("waw_drop", {31'd0, reg_write}, 32'd0);

        md_valid = 1; md_rd = 5'd9; md_result = 32'h99;
        alu_wr(5'd2, 32'h1);
        md_rd = 5'd10; md_result = 32'hAA;
        alu_wr(5'd3, 32'h2);
        md_valid = 0;
        chk("full_rdy", {31'd0, md_ready}, 32'd0);
        chk("full_pm", pend_mask, 32'h600);
`endif
        alu_wr(5'd4, 32'h3);
        rst_n = 1'b0;
        #1;
        chk("mid_rw", {31'd0, reg_write}, 32'd0);
        chk("mid_rd", {27'd0, rd_wb}, 32'd0);
        chk("mid_rdy", {31'd0, md_ready}, 32'd0);
        chk("mid_pm", pend_mask, 32'd0);
        chk("mid_st", {31'd0, wb_stall}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        chk("rel_rdy", {31'd0, md_ready}, {31'd0, MD_ON});
        chk("rel_pm", pend_mask, 32'd0);
        idle();
        chk("rel_empty", {31'd0, reg_write}, 32'd0);
        repeat (2) idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
